// File: rtl/mmu_xlate_pkg.sv
// mmu_pkg -- shared definitions for the mmu_xlate address-translation slice.
//
// Contents:
//   state_e        : translation FSM states (IDLE / LOOKUP / RESP)
//   EXC_*          : MIPS exception codes raised by the translator
//   SEG_KSEG01     : vaddr[31:30] value of the unmapped kseg0/kseg1 window
//   CCA_CACHED     : cache-coherency attribute meaning "cacheable"
//   rsp_t          : response payload carried from decode to the rsp_* ports
//   is_unmapped()  : segment decode
//   unmapped_rsp() : response for kseg0/kseg1
//   mapped_rsp()   : response for a mapped access given the page attributes
package mmu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_MOD  = 5'd1;
  localparam logic [4:0] EXC_TLBL = 5'd2;
  localparam logic [4:0] EXC_TLBS = 5'd3;

  localparam logic [1:0] SEG_KSEG01 = 2'b10;
  localparam logic [2:0] CCA_CACHED = 3'd3;

  localparam int VPN_W          = 20;
  localparam int UTLB_MAX_DEPTH = 4;

  typedef struct packed {
    logic [31:0] paddr;
    logic        cached;
    logic        exc;
    logic [4:0]  exccode;
    logic [31:0] badvaddr;
  } rsp_t;

  function automatic logic is_unmapped(input logic [31:0] vaddr);
    return (vaddr[31:30] == SEG_KSEG01);
  endfunction

  // kseg0/kseg1 strip the top three bits; kseg0 (vaddr[29]=0) is cacheable
  function automatic rsp_t unmapped_rsp(input logic [31:0] vaddr);
    rsp_t r;
    r          = '0;
    r.paddr    = {3'b000, vaddr[28:0]};
    r.cached   = ~vaddr[29];
    return r;
  endfunction

  // Missing/invalid page beats a dirty-bit fault; faults zero the paddr
  function automatic rsp_t mapped_rsp(input logic [31:0]      vaddr,
                                      input logic             we,
                                      input logic             hit,
                                      input logic             valid,
                                      input logic             dirty,
                                      input logic [VPN_W-1:0] ppn,
                                      input logic             cached);
    rsp_t r;
    r = '0;
    if (!hit || !valid) begin
      r.exc      = 1'b1;
      r.exccode  = we ? EXC_TLBS : EXC_TLBL;
      r.badvaddr = vaddr;
    end else if (we && !dirty) begin
      r.exc      = 1'b1;
      r.exccode  = EXC_MOD;
      r.badvaddr = vaddr;
    end else begin
      r.paddr    = {ppn, vaddr[11:0]};
      r.cached   = cached;
    end
    return r;
  endfunction

endpackage

// File: rtl/mmu_xlate_if.sv
// mmu_xlate_if -- bundle of every non-clock/reset signal of mmu_xlate.
//
//   req_*  : core request handshake (valid/ready, vaddr, we=1 for store)
//   tlb_*  : JTLB lookup address out, JTLB hit/paddr/opts {C[2:0],D,V} in,
//            tlb_flush_i pulses on every TLB write
//   rsp_*  : response handshake and payload (paddr, cached, exception info)
//
// Modports: slave = the translator, master = the core/JTLB environment.
interface mmu_xlate_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_vaddr_i;
  logic        req_we_i;

  logic [31:0] tlb_vaddr_o;
  logic        tlb_hit_i;
  logic [31:0] tlb_paddr_i;
  logic [4:0]  tlb_opts_i;
  logic        tlb_flush_i;

  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_paddr_o;
  logic        rsp_cached_o;
  logic        rsp_exc_o;
  logic [4:0]  rsp_exccode_o;
  logic [31:0] rsp_badvaddr_o;

  modport slave (
    input  req_valid_i, req_vaddr_i, req_we_i,
    input  tlb_hit_i, tlb_paddr_i, tlb_opts_i, tlb_flush_i,
    input  rsp_ready_i,
    output req_ready_o, tlb_vaddr_o,
    output rsp_valid_o, rsp_paddr_o, rsp_cached_o, rsp_exc_o,
    output rsp_exccode_o, rsp_badvaddr_o
  );

  modport master (
    output req_valid_i, req_vaddr_i, req_we_i,
    output tlb_hit_i, tlb_paddr_i, tlb_opts_i, tlb_flush_i,
    output rsp_ready_i,
    input  req_ready_o, tlb_vaddr_o,
    input  rsp_valid_o, rsp_paddr_o, rsp_cached_o, rsp_exc_o,
    input  rsp_exccode_o, rsp_badvaddr_o
  );
endinterface

// File: rtl/mmu_xlate_utlb.sv
// mmu_utlb -- fully associative micro-TLB in front of the JTLB.
//
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   lookup_vpn_i        : page number to look up (combinational hit/data out)
//   hit_o, ppn_o,
//   cached_o, dirty_o   : lookup result (data is zero on miss)
//   fill_i, fill_*_i    : write one entry at the round-robin pointer
//   flush_i             : invalidate every entry; wins over a same-cycle fill
//
// Only valid pages are ever filled, so a hit implies V=1; D is kept so a
// store can still take a Mod fault without going back to the JTLB.
module mmu_utlb
  import mmu_pkg::*;
#(
  parameter int UTLB_DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [VPN_W-1:0] lookup_vpn_i,
  output logic             hit_o,
  output logic [VPN_W-1:0] ppn_o,
  output logic             cached_o,
  output logic             dirty_o,
  input  logic             fill_i,
  input  logic [VPN_W-1:0] fill_vpn_i,
  input  logic [VPN_W-1:0] fill_ppn_i,
  input  logic             fill_cached_i,
  input  logic             fill_dirty_i,
  input  logic             flush_i
);

  logic [UTLB_DEPTH-1:0] valid_r;
  logic [UTLB_DEPTH-1:0] cached_r;
  logic [UTLB_DEPTH-1:0] dirty_r;
  logic [VPN_W-1:0]      tag_r [UTLB_DEPTH];
  logic [VPN_W-1:0]      ppn_r [UTLB_DEPTH];
  logic [1:0]            ptr_r;
  logic [UTLB_DEPTH-1:0] match_s;

  // Tag compare; tags are unique (fills only follow a miss) so AND-OR muxing is safe
  always_comb begin
    match_s  = '0;
    ppn_o    = '0;
    cached_o = 1'b0;
    dirty_o  = 1'b0;
    for (int i = 0; i < UTLB_DEPTH; i++) begin
      match_s[i] = valid_r[i] && (tag_r[i] == lookup_vpn_i);
      ppn_o      = ppn_o | ({VPN_W{match_s[i]}} & ppn_r[i]);
      cached_o   = cached_o | (match_s[i] & cached_r[i]);
      dirty_o    = dirty_o | (match_s[i] & dirty_r[i]);
    end
  end

  assign hit_o = |match_s;

  // Entry storage, flush and round-robin replacement pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_r  <= '0;
      cached_r <= '0;
      dirty_r  <= '0;
      ptr_r    <= 2'd0;
      for (int i = 0; i < UTLB_DEPTH; i++) begin
        tag_r[i] <= '0;
        ppn_r[i] <= '0;
      end
    end else if (flush_i) begin
      valid_r <= '0;
    end else if (fill_i) begin
      for (int i = 0; i < UTLB_DEPTH; i++) begin
        if (int'(ptr_r) == i) begin
          valid_r[i]  <= 1'b1;
          tag_r[i]    <= fill_vpn_i;
          ppn_r[i]    <= fill_ppn_i;
          cached_r[i] <= fill_cached_i;
          dirty_r[i]  <= fill_dirty_i;
        end
      end
      if (int'(ptr_r) == UTLB_DEPTH - 1) begin
        ptr_r <= 2'd0;
      end else begin
        ptr_r <= ptr_r + 2'd1;
      end
    end
  end

endmodule

// File: rtl/mmu_xlate.sv
// mmu_xlate -- MIPS-style virtual-to-physical translation, one request in flight.
//
// Ports:
//   clk_i  : clock, all state on the rising edge
//   rst_i  : asynchronous active-high reset; abandons any in-flight request
//   bus    : mmu_xlate_if.slave (request, JTLB lookup, response handshakes)
//
// Timing from the accept cycle N:
//   kseg0/kseg1            -> response in N+1
//   mapped, micro-TLB hit  -> response in N+1
//   mapped, otherwise      -> JTLB looked up in N+1, response in N+2
//
// Build option MMU_UTLB_EN: when defined the micro-TLB (mmu_utlb, UTLB_DEPTH
// entries) is built and flushed by tlb_flush_i; when undefined every mapped
// access takes the JTLB path, tlb_flush_i is ignored and UTLB_DEPTH only
// gets its range check.
module mmu_xlate
  import mmu_pkg::*;
#(
  parameter int UTLB_DEPTH = 2
) (
  input logic        clk_i,
  input logic        rst_i,
  mmu_xlate_if.slave bus
);

  state_e           state_r;
  state_e           state_nxt_s;
  logic             we_r;
  logic [31:0]      tlb_vaddr_r;
  logic [31:0]      tlb_vaddr_nxt_s;
  rsp_t             rsp_r;
  rsp_t             rsp_nxt_s;
  logic             accept_s;
  logic             unmapped_s;
  logic             jtlb_cached_s;
  logic             req_ready_s;
  logic             rsp_valid_s;
  logic             utlb_hit_s;
  logic [VPN_W-1:0] utlb_ppn_s;
  logic             utlb_cached_s;
  logic             utlb_dirty_s;

  if (UTLB_DEPTH < 1 || UTLB_DEPTH > UTLB_MAX_DEPTH) begin : g_bad_depth
    $error("mmu_xlate: UTLB_DEPTH must be in 1..4");
  end

  assign accept_s      = bus.req_valid_i && (state_r == ST_IDLE);
  assign unmapped_s    = is_unmapped(bus.req_vaddr_i);
  assign jtlb_cached_s = (bus.tlb_opts_i[4:2] == CCA_CACHED);

`ifdef MMU_UTLB_EN
  logic fill_s;

  // Cache a JTLB result only for a valid page; tlb_vaddr_r still holds the request
  assign fill_s = (state_r == ST_LOOKUP) && bus.tlb_hit_i && bus.tlb_opts_i[0];

  mmu_utlb #(
    .UTLB_DEPTH (UTLB_DEPTH)
  ) u_utlb (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .lookup_vpn_i  (bus.req_vaddr_i[31:12]),
    .hit_o         (utlb_hit_s),
    .ppn_o         (utlb_ppn_s),
    .cached_o      (utlb_cached_s),
    .dirty_o       (utlb_dirty_s),
    .fill_i        (fill_s),
    .fill_vpn_i    (tlb_vaddr_r[31:12]),
    .fill_ppn_i    (bus.tlb_paddr_i[31:12]),
    .fill_cached_i (jtlb_cached_s),
    .fill_dirty_i  (bus.tlb_opts_i[1]),
    .flush_i       (bus.tlb_flush_i)
  );
`else
  assign utlb_hit_s    = 1'b0;
  assign utlb_ppn_s    = '0;
  assign utlb_cached_s = 1'b0;
  assign utlb_dirty_s  = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: unmapped and micro-TLB hits skip the JTLB cycle
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (unmapped_s || utlb_hit_s)) begin
          state_nxt_s = ST_RESP;
        end else if (accept_s) begin
          state_nxt_s = ST_LOOKUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOOKUP: state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (bus.rsp_ready_i) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: handshakes decode directly from the state register
  always_comb begin
    req_ready_s = 1'b0;
    rsp_valid_s = 1'b0;
    case (state_r)
      ST_IDLE:   req_ready_s = 1'b1;
      ST_LOOKUP: req_ready_s = 1'b0;
      ST_RESP:   rsp_valid_s = 1'b1;
      default:   req_ready_s = 1'b0;
    endcase
  end

  // Next response payload: captured on a direct accept or at the end of LOOKUP, else held
  always_comb begin
    rsp_nxt_s = rsp_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && unmapped_s) begin
          rsp_nxt_s = unmapped_rsp(bus.req_vaddr_i);
        end else if (accept_s && utlb_hit_s) begin
          rsp_nxt_s = mapped_rsp(bus.req_vaddr_i, bus.req_we_i, 1'b1, 1'b1,
                                 utlb_dirty_s, utlb_ppn_s, utlb_cached_s);
        end else begin
          rsp_nxt_s = rsp_r;
        end
      end
      ST_LOOKUP: begin
        rsp_nxt_s = mapped_rsp(tlb_vaddr_r, we_r, bus.tlb_hit_i, bus.tlb_opts_i[0],
                               bus.tlb_opts_i[1], bus.tlb_paddr_i[31:12], jtlb_cached_s);
      end
      ST_RESP: rsp_nxt_s = rsp_r;
      default: rsp_nxt_s = '0;
    endcase
  end

  // The JTLB address is non-zero only while in LOOKUP
  always_comb begin
    if (state_nxt_s == ST_LOOKUP) begin
      tlb_vaddr_nxt_s = bus.req_vaddr_i;
    end else begin
      tlb_vaddr_nxt_s = 32'd0;
    end
  end

  // Request context and registered response payload
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_r        <= 1'b0;
      tlb_vaddr_r <= 32'd0;
      rsp_r       <= '0;
    end else begin
      if (accept_s) begin
        we_r <= bus.req_we_i;
      end
      tlb_vaddr_r <= tlb_vaddr_nxt_s;
      rsp_r       <= rsp_nxt_s;
    end
  end

  assign bus.req_ready_o    = req_ready_s;
  assign bus.tlb_vaddr_o    = tlb_vaddr_r;
  assign bus.rsp_valid_o    = rsp_valid_s;
  assign bus.rsp_paddr_o    = rsp_r.paddr;
  assign bus.rsp_cached_o   = rsp_r.cached;
  assign bus.rsp_exc_o      = rsp_r.exc;
  assign bus.rsp_exccode_o  = rsp_r.exccode;
  assign bus.rsp_badvaddr_o = rsp_r.badvaddr;

endmodule

// File: tb/tb_mmu_xlate.sv
// tb_mmu_xlate -- self-checking bench for mmu_xlate (directed + random).
// Reference model: micro-TLB kept as DEPTH slots filled at (fills % DEPTH),
// present only when MMU_UTLB_EN is defined.
module tb_mmu_xlate;

`ifdef MMU_UTLB_EN
  localparam bit UTLB_ON = 1'b1;
`else
  localparam bit UTLB_ON = 1'b0;
`endif
  localparam int DEPTH = 2;

  logic clk_i = 1'b0;
  logic rst_i;
  mmu_xlate_if bus ();

  mmu_xlate #(.UTLB_DEPTH(DEPTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // reference micro-TLB
  bit          m_v   [DEPTH];
  logic [19:0] m_vpn [DEPTH];
  logic [19:0] m_ppn [DEPTH];
  logic        m_c   [DEPTH];
  logic        m_d   [DEPTH];
  int          m_fills;

  task automatic model_flush();
    for (int i = 0; i < DEPTH; i++) m_v[i] = 1'b0;
  endtask

  task automatic model_reset();
    model_flush();
    m_fills = 0;
  endtask

  // Expected response and latency for one request; updates the reference micro-TLB
  task automatic model_req(input logic [31:0] va, input logic we, input logic jh,
                           input logic [31:0] jpa, input logic [4:0] jo, input bit flush_now,
                           output int lat, output logic [31:0] pa, output logic ca,
                           output logic ex, output logic [4:0] code, output logic [31:0] bad);
    int slot;
    logic h, v, d, c;
    logic [19:0] ppn;
    pa = 32'd0; ca = 1'b0; ex = 1'b0; code = 5'd0; bad = 32'd0;
    if (va[31:30] == 2'b10) begin
      lat = 1;
      pa  = {3'b000, va[28:0]};
      ca  = ~va[29];
    end else begin
      slot = -1;
      if (UTLB_ON) begin
        for (int i = 0; i < DEPTH; i++)
          if (m_v[i] && m_vpn[i] == va[31:12]) slot = i;
      end
      if (slot >= 0) begin
        lat = 1; h = 1'b1; v = 1'b1;
        d = m_d[slot]; c = m_c[slot]; ppn = m_ppn[slot];
      end else begin
        lat = 2; h = jh; v = jo[0]; d = jo[1];
        c = (jo[4:2] == 3'd3); ppn = jpa[31:12];
        if (UTLB_ON && jh && jo[0] && !flush_now) begin
          m_v[m_fills % DEPTH]   = 1'b1;
          m_vpn[m_fills % DEPTH] = va[31:12];
          m_ppn[m_fills % DEPTH] = ppn;
          m_c[m_fills % DEPTH]   = c;
          m_d[m_fills % DEPTH]   = d;
          m_fills++;
        end
      end
      if (!h || !v) begin
        ex = 1'b1; code = we ? 5'd3 : 5'd2; bad = va;
      end else if (we && !d) begin
        ex = 1'b1; code = 5'd1; bad = va;
      end else begin
        pa = {ppn, va[11:0]}; ca = c;
      end
    end
    if (flush_now) model_flush();
  endtask

  task automatic pulse_flush();
    bus.tlb_flush_i = 1'b1;
    @(posedge clk_i); #1;
    bus.tlb_flush_i = 1'b0;
    model_flush();
  endtask

  // One complete transaction: request, latency, payload, optional stall, handshake
  task automatic xact(input logic [31:0] va, input logic we, input logic jh,
                      input logic [31:0] jpa, input logic [4:0] jo, input bit flush_now,
                      input int stall, input string tag);
    int e_lat, lat, w;
    logic [31:0] e_pa, e_bad;
    logic e_ca, e_ex;
    logic [4:0] e_code;
    logic [70:0] snap;
    model_req(va, we, jh, jpa, jo, flush_now, e_lat, e_pa, e_ca, e_ex, e_code, e_bad);
    bus.req_valid_i = 1'b1; bus.req_vaddr_i = va; bus.req_we_i = we;
    bus.tlb_hit_i = jh; bus.tlb_paddr_i = jpa; bus.tlb_opts_i = jo; bus.rsp_ready_i = 1'b0;
    n_cmp++;
    if (bus.req_ready_o !== 1'b1) begin
      n_err++; $display("FAIL %s req_ready: got %b want 1", tag, bus.req_ready_o);
    end
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b0; bus.req_vaddr_i = $urandom; bus.req_we_i = ~we;
    bus.tlb_flush_i = flush_now;
    lat = 0;
    if (bus.rsp_valid_o === 1'b1) begin
      lat = 1;
    end else begin
      n_cmp++;
      if (bus.tlb_vaddr_o !== va) begin
        n_err++; $display("FAIL %s tlb_vaddr: got %h want %h", tag, bus.tlb_vaddr_o, va);
      end
    end
    @(posedge clk_i); #1;
    bus.tlb_flush_i = 1'b0;
    bus.tlb_hit_i = 1'($urandom); bus.tlb_paddr_i = $urandom; bus.tlb_opts_i = 5'($urandom);
    if (lat == 0) begin
      w = 2;
      while (bus.rsp_valid_o !== 1'b1 && w < 6) begin
        @(posedge clk_i); #1; w++;
      end
      lat = (bus.rsp_valid_o === 1'b1) ? w : 99;
    end
    n_cmp++;
    if (lat != e_lat) begin
      n_err++; $display("FAIL %s latency: got %0d want %0d", tag, lat, e_lat);
    end
    n_cmp++;
    if (bus.rsp_paddr_o !== e_pa) begin
      n_err++; $display("FAIL %s paddr: got %h want %h", tag, bus.rsp_paddr_o, e_pa);
    end
    n_cmp++;
    if ({bus.rsp_exc_o, bus.rsp_exccode_o} !== {e_ex, e_code}) begin
      n_err++; $display("FAIL %s exc/code: got %b/%0d want %b/%0d", tag,
                        bus.rsp_exc_o, bus.rsp_exccode_o, e_ex, e_code);
    end
    n_cmp++;
    if (bus.rsp_badvaddr_o !== e_bad) begin
      n_err++; $display("FAIL %s badvaddr: got %h want %h", tag, bus.rsp_badvaddr_o, e_bad);
    end
    if (!e_ex) begin
      n_cmp++;
      if (bus.rsp_cached_o !== e_ca) begin
        n_err++; $display("FAIL %s cached: got %b want %b", tag, bus.rsp_cached_o, e_ca);
      end
    end
    n_cmp++;
    if (bus.tlb_vaddr_o !== 32'd0) begin
      n_err++; $display("FAIL %s tlb_vaddr_resp: got %h want 0", tag, bus.tlb_vaddr_o);
    end
    snap = {bus.rsp_paddr_o, bus.rsp_cached_o, bus.rsp_exc_o, bus.rsp_exccode_o, bus.rsp_badvaddr_o};
    for (int k = 0; k < stall; k++) begin
      bus.req_valid_i = 1'b1;
      @(posedge clk_i); #1;
      n_cmp++;
      if ({bus.rsp_valid_o, bus.req_ready_o, bus.rsp_paddr_o, bus.rsp_cached_o, bus.rsp_exc_o,
           bus.rsp_exccode_o, bus.rsp_badvaddr_o} !== {1'b1, 1'b0, snap}) begin
        n_err++; $display("FAIL %s stall_hold: got v=%b rdy=%b %h want v=1 rdy=0 %h", tag,
                          bus.rsp_valid_o, bus.req_ready_o,
                          {bus.rsp_paddr_o, bus.rsp_cached_o, bus.rsp_exc_o,
                           bus.rsp_exccode_o, bus.rsp_badvaddr_o}, snap);
      end
    end
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    bus.rsp_ready_i = 1'b0;
    n_cmp++;
    if ({bus.rsp_valid_o, bus.req_ready_o} !== 2'b01) begin
      n_err++; $display("FAIL %s release: got v=%b rdy=%b want v=0 rdy=1", tag,
                        bus.rsp_valid_o, bus.req_ready_o);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    bus.req_valid_i = 1'b0; bus.req_vaddr_i = 32'd0; bus.req_we_i = 1'b0;
    bus.tlb_hit_i = 1'b0; bus.tlb_paddr_i = 32'd0; bus.tlb_opts_i = 5'd0;
    bus.tlb_flush_i = 1'b0; bus.rsp_ready_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    n_cmp++;
    if ({bus.rsp_valid_o, bus.req_ready_o, bus.rsp_exc_o, bus.rsp_cached_o} !== 4'b0100) begin
      n_err++; $display("FAIL reset_ctl: got %b want 0100",
                        {bus.rsp_valid_o, bus.req_ready_o, bus.rsp_exc_o, bus.rsp_cached_o});
    end
    n_cmp++;
    if ({bus.rsp_paddr_o, bus.rsp_badvaddr_o, bus.rsp_exccode_o, bus.tlb_vaddr_o} !== 101'd0) begin
      n_err++; $display("FAIL reset_data: got %h/%h/%h/%h want zeros", bus.rsp_paddr_o,
                        bus.rsp_badvaddr_o, bus.rsp_exccode_o, bus.tlb_vaddr_o);
    end
    rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_unmapped();
    xact(32'h8000_1234, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 0, "kseg0");
    xact(32'hA000_0010, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 0, "kseg1");
    for (int i = 0; i < 10; i++)
      xact({2'b10, 30'($urandom)}, 1'($urandom), 1'($urandom), $urandom, 5'($urandom),
           1'b0, 0, "unmapped_rnd");
  endtask

  task automatic test_mapped();
    xact(32'h0040_0004, 1'b0, 1'b1, 32'h0123_4000, 5'b01111, 1'b0, 0, "map_first");
    xact(32'h0040_0004, 1'b0, 1'b0, 32'hDEAD_B000, 5'b00000, 1'b0, 0, "map_repeat");
  endtask

  task automatic test_exceptions();
    pulse_flush();
    xact(32'h0040_0008, 1'b1, 1'b0, 32'h0555_5000, 5'b01111, 1'b0, 0, "st_nohit");
    xact(32'h0040_0008, 1'b1, 1'b1, 32'h0555_5000, 5'b01101, 1'b0, 0, "st_mod");
    xact(32'h0040_000C, 1'b1, 1'b1, 32'h0555_5000, 5'b01111, 1'b0, 0, "st_mod_again");
    xact(32'h0040_0010, 1'b0, 1'b0, 32'h0666_6000, 5'b01111, 1'b0, 0, "ld_same_page");
    xact(32'h1000_0000, 1'b0, 1'b1, 32'h0777_7000, 5'b01110, 1'b0, 0, "ld_invalid");
    xact(32'hC000_2000, 1'b1, 1'b1, 32'h0888_8000, 5'b00011, 1'b0, 0, "st_kseg2_ok");
  endtask

  task automatic test_flush();
    xact(32'h0077_7100, 1'b0, 1'b1, 32'h0AAA_A000, 5'b01111, 1'b0, 0, "fl_fill");
    pulse_flush();
    xact(32'h0077_7200, 1'b0, 1'b1, 32'h0BBB_B000, 5'b01111, 1'b0, 0, "fl_after_flush");
    xact(32'h0088_8000, 1'b0, 1'b1, 32'h0CCC_C000, 5'b01111, 1'b1, 0, "fl_coincident");
    xact(32'h0088_8004, 1'b0, 1'b1, 32'h0DDD_D000, 5'b01111, 1'b0, 0, "fl_coinc_next");
  endtask

  task automatic test_stall();
    xact(32'h9FFF_FFFC, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0, 5, "stall_unmapped");
    xact(32'h0123_4567, 1'b1, 1'b1, 32'h0FED_C000, 5'b01011, 1'b0, 5, "stall_mapped");
  endtask

  task automatic test_reset_lookup();
    pulse_flush();
    bus.req_valid_i = 1'b1; bus.req_vaddr_i = 32'h0040_3000; bus.req_we_i = 1'b0;
    bus.tlb_hit_i = 1'b1; bus.tlb_paddr_i = 32'h0123_0000; bus.tlb_opts_i = 5'b01111;
    @(posedge clk_i); #1;
    bus.req_valid_i = 1'b0;
    n_cmp++;
    if (bus.tlb_vaddr_o !== 32'h0040_3000) begin
      n_err++; $display("FAIL rst_lookup_vaddr: got %h want 00403000", bus.tlb_vaddr_o);
    end
    rst_i = 1'b1;
    #1;
    n_cmp++;
    if ({bus.rsp_valid_o, bus.req_ready_o, bus.tlb_vaddr_o} !== {2'b01, 32'd0}) begin
      n_err++; $display("FAIL rst_lookup_async: got v=%b rdy=%b tv=%h want v=0 rdy=1 tv=0",
                        bus.rsp_valid_o, bus.req_ready_o, bus.tlb_vaddr_o);
    end
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i); #1;
      n_cmp++;
      if ({bus.rsp_valid_o, bus.req_ready_o} !== 2'b01) begin
        n_err++; $display("FAIL rst_lookup_norsp: got v=%b rdy=%b want v=0 rdy=1",
                          bus.rsp_valid_o, bus.req_ready_o);
      end
    end
    xact(32'h0040_3000, 1'b0, 1'b1, 32'h0123_0000, 5'b01111, 1'b0, 0, "rst_lookup_after");
  endtask

  task automatic test_random();
    logic [19:0] pages [5];
    logic [31:0] va;
    pages[0] = 20'h00400; pages[1] = 20'h00401; pages[2] = 20'h00402;
    pages[3] = 20'hC0000; pages[4] = 20'hE0010;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) va = {2'b10, 30'($urandom)};
      else va = {pages[$urandom_range(0, 4)], 12'($urandom)};
      if ($urandom_range(0, 19) == 0) pulse_flush();
      xact(va, 1'($urandom), ($urandom_range(0, 5) != 0), $urandom, 5'($urandom),
           ($urandom_range(0, 9) == 0), $urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    test_reset();
    test_unmapped();
    test_mapped();
    test_exceptions();
    test_flush();
    test_stall();
    test_reset_lookup();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mmu_xlate.md
MMU_XLATE -- requirements
Module: mmu_xlate

Interface
REQ-001 SHALL have parameter UTLB_DEPTH, default 2, number of micro-TLB entries (legal 1..4).
REQ-002 SHALL have port clk_i  in  1  clock, all state on rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports req_valid_i in 1, req_ready_o out 1, req_vaddr_i in 32, req_we_i in 1 (1=store), forming the core-side request handshake.
REQ-005 SHALL have ports tlb_vaddr_o out 32 (to JTLB lookup address), tlb_hit_i in 1, tlb_paddr_i in 32, tlb_opts_i in 5 ({C[2:0],D,V}).
REQ-006 SHALL have port tlb_flush_i  in  1  pulse on every TLB write, invalidating the micro-TLB.
REQ-007 SHALL have ports rsp_valid_o out 1, rsp_ready_i in 1, rsp_paddr_o out 32, rsp_cached_o out 1, rsp_exc_o out 1, rsp_exccode_o out 5, rsp_badvaddr_o out 32.

Function
REQ-008 SHALL implement FSM states IDLE, LOOKUP, RESP; req_ready_o = (state==IDLE); one request outstanding.
REQ-009 SHALL, on accept in IDLE (cycle N) with vaddr[31:30]==2'b10 (kseg0/kseg1), go to RESP with rsp_paddr_o = {3'b000,vaddr[28:0]}, rsp_valid_o high in N+1.
REQ-010 SHALL set rsp_cached_o=1 for kseg0 (vaddr[29]=0) and 0 for kseg1.
REQ-011 SHALL, on accept of a mapped address (kuseg/kseg2/kseg3) hitting the micro-TLB (tag vaddr[31:12]), go directly to RESP; rsp_valid_o in N+1.
REQ-012 SHALL, on micro-TLB miss, go to LOOKUP, drive tlb_vaddr_o from the registered vaddr, sample JTLB outputs at end of N+1, go to RESP; rsp_valid_o in N+2.
REQ-013 SHALL form mapped paddr as {tlb_paddr_i[31:12],vaddr[11:0]} and rsp_cached_o = (C==3'd3).
REQ-014 SHALL raise rsp_exc_o with exccode 2 (TLBL, load) or 3 (TLBS, store) when tlb_hit_i=0 or V=0.
REQ-015 SHALL raise exccode 1 (Mod) for a store with hit, V=1, D=0.
REQ-016 SHALL set rsp_badvaddr_o = request vaddr whenever rsp_exc_o=1, else 0; rsp_paddr_o=0 on exception.
REQ-017 SHALL fill the micro-TLB only on hit with V=1 (D stored, re-checked on every store hit), replacement round-robin pointer advancing per fill and wrapping at UTLB_DEPTH-1.
REQ-018 SHALL hold all rsp_* stable while rsp_valid_o=1 and rsp_ready_i=0; RESP->IDLE on rsp_ready_i.
REQ-019 SHALL, on tlb_flush_i, clear all micro-TLB valid bits at that edge; flush coincident with a fill wins (no entry written); an in-flight LOOKUP still responds with the sampled JTLB result.
REQ-020 SHALL drive tlb_vaddr_o = 0 outside LOOKUP.

Reset
REQ-021 SHALL, on rst_i, force state IDLE, all micro-TLB valid bits 0, round-robin pointer 0, rsp_valid_o 0, rsp_exc_o 0, rsp_paddr_o/rsp_badvaddr_o/rsp_exccode_o 0, rsp_cached_o 0.
REQ-022 SHALL abandon any in-flight request when rst_i asserts mid-operation; no response is produced for it.

Configuration
REQ-023 SHALL compile the micro-TLB only when MMU_UTLB_EN is defined; without it every mapped access takes the LOOKUP path (N+2), tlb_flush_i is ignored, UTLB_DEPTH unused.

Structure
REQ-024 SHALL place exccode constants (MOD=1, TLBL=2, TLBS=3), segment decode constants and the FSM state enum in shared package mmu_pkg.
REQ-025 SHALL implement the micro-TLB as sub-module mmu_utlb (tag/data arrays, valid bits, round-robin pointer, flush).

Verification
REQ-026 SHALL check: load vaddr 0x8000_1234 -> N+1 rsp paddr 0x0000_1234, cached=1, exc=0; vaddr 0xA000_0010 -> paddr 0x0000_0010, cached=0.
REQ-027 SHALL check: load 0x0040_0004, JTLB hit paddr 0x0123_4000 opts 5'b01111 -> N+2 paddr 0x0123_4004 cached=1; repeat -> N+1 (MMU_UTLB_EN).
REQ-028 SHALL check: store 0x0040_0008 with tlb_hit_i=0 -> exc=1 code 3 badvaddr 0x0040_0008; same with hit, V=1, D=0 -> code 1.
REQ-029 SHALL check: fill entry, pulse tlb_flush_i, re-access same page -> LOOKUP path again (N+2); flush coincident with fill -> next access misses.
REQ-030 SHALL check: rsp_ready_i held low 5 cycles -> rsp_* stable, req_ready_o=0; rst_i asserted during LOOKUP -> rsp_valid_o=0, state IDLE next cycle.
